elev_request_tracker: RTL and testbench

//  Upstream feeder for the per-state next-state controllers (full stop/up/down, half).
//  - Latches absolute per-floor hall and car requests.
//  - Tracks the car's absolute floor from the registered pos/dir/open state.
//  - Clears requests once they are served.
//  - Presents the relative 3-bit request vectors the controllers consume:
//    [0] at current floor, [1] any floor above, [2] any floor below.

---
 rtl/elev_pkg.sv | 20 ++
 rtl/elev_request_tracker_if.sv | 36 +++
 rtl/elev_rel_map.sv | 32 +++
 rtl/elev_request_tracker.sv | 96 +++++++++
 tb/tb_elev_request_tracker.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/elev_pkg.sv
`default_nettype none
// ============================================================================
//  Module : elev_pkg
//  Brief  : Shared position/direction encodings and default floor count.
//  Rev    : 1.0
// ============================================================================
package elev_pkg;

    localparam int DEFAULT_NUM_FLOORS = 4;

    localparam logic [1:0] POS_FLOOR   = 2'b00;
    localparam logic [1:0] POS_HALF_UP = 2'b01;
    localparam logic [1:0] POS_HALF_DN = 2'b10;

    localparam logic [1:0] DIR_IDLE = 2'b00;
    localparam logic [1:0] DIR_UP   = 2'b01;
    localparam logic [1:0] DIR_DN   = 2'b10;

endpackage : elev_pkg
`default_nettype wire

// File: rtl/elev_request_tracker_if.sv
`default_nettype none
// ============================================================================
//  Module : elev_request_tracker_if
//  Brief  : Request, car-state and relative-vector bundle of the tracker.
//  Rev    : 1.0
// ============================================================================
interface elev_request_tracker_if
    import elev_pkg::*;
#(
    parameter int NUM_FLOORS = DEFAULT_NUM_FLOORS,
    parameter int FLOOR_W    = $clog2(NUM_FLOORS)
);
    logic [NUM_FLOORS-1:0] hall_up_req;
    logic [NUM_FLOORS-1:0] hall_dn_req;
    logic [NUM_FLOORS-1:0] car_req;
    logic [1:0]            pos_cur;
    logic                  open_cur;
    logic [1:0]            dir_cur;
    logic [2:0]            button_up;
    logic [2:0]            button_down;
    logic [2:0]            button_in;
    logic [FLOOR_W-1:0]    floor_cur;
    logic                  pend_any;
    logic                  range_err;

    modport master (
        output hall_up_req, hall_dn_req, car_req, pos_cur, open_cur, dir_cur,
        input  button_up, button_down, button_in, floor_cur, pend_any, range_err
    );

    modport slave (
        input  hall_up_req, hall_dn_req, car_req, pos_cur, open_cur, dir_cur,
        output button_up, button_down, button_in, floor_cur, pend_any, range_err
    );
endinterface : elev_request_tracker_if
`default_nettype wire

// File: rtl/elev_rel_map.sv
`default_nettype none
// ============================================================================
//  Module : elev_rel_map
//  Brief  : Absolute pending vector + floor -> {below, above, at} vector.
//  Rev    : 1.0
// ============================================================================
module elev_rel_map
    import elev_pkg::*;
#(
    parameter int NUM_FLOORS = DEFAULT_NUM_FLOORS,
    parameter int FLOOR_W    = $clog2(NUM_FLOORS)
) (
    input  wire logic [NUM_FLOORS-1:0] pending,
    input  wire logic [FLOOR_W-1:0]    floor_idx,
    output logic      [2:0]            rel
);

    logic [NUM_FLOORS-1:0] w_at;
    logic [NUM_FLOORS-1:0] w_above;
    logic [NUM_FLOORS-1:0] w_below;

    for (genvar j = 0; j < NUM_FLOORS; j++) begin : g_floor
        localparam logic [FLOOR_W-1:0] c_idx = FLOOR_W'(j);
        assign w_at[j]    = pending[j] & (c_idx == floor_idx);
        assign w_above[j] = pending[j] & (c_idx >  floor_idx);
        assign w_below[j] = pending[j] & (c_idx <  floor_idx);
    end

    assign rel = {|w_below, |w_above, |w_at};

endmodule : elev_rel_map
`default_nettype wire

// File: rtl/elev_request_tracker.sv
`default_nettype none
// ============================================================================
//  Module : elev_request_tracker
//  Brief  : Latches hall/car requests, tracks the car floor, clears served
//           requests and presents relative request vectors to the controllers.
//  Rev    : 1.0
// ============================================================================
module elev_request_tracker
    import elev_pkg::*;
#(
    parameter int NUM_FLOORS = DEFAULT_NUM_FLOORS,
    parameter int FLOOR_W    = $clog2(NUM_FLOORS)
) (
    input  wire logic               clk,
    input  wire logic               reset,
    elev_request_tracker_if.slave   bus
);

    // Hall-up at the top floor and hall-down at the bottom floor do not exist.
    localparam logic [NUM_FLOORS-1:0] c_up_mask = {1'b0, {(NUM_FLOORS-1){1'b1}}};
    localparam logic [NUM_FLOORS-1:0] c_dn_mask = {{(NUM_FLOORS-1){1'b1}}, 1'b0};
    localparam logic [FLOOR_W-1:0]    c_top     = FLOOR_W'(NUM_FLOORS - 1);
    localparam logic [FLOOR_W-1:0]    c_bottom  = '0;

    logic [NUM_FLOORS-1:0] r_pend_up;
    logic [NUM_FLOORS-1:0] r_pend_dn;
    logic [NUM_FLOORS-1:0] r_pend_in;
    logic [FLOOR_W-1:0]    r_floor;
    logic [1:0]            r_pos_prev;
    logic                  r_range_err;

    logic                  w_clr_en;
    logic [NUM_FLOORS-1:0] w_sel;
    logic [NUM_FLOORS-1:0] w_clr_up;
    logic [NUM_FLOORS-1:0] w_clr_dn;
    logic [NUM_FLOORS-1:0] w_clr_in;
    logic                  w_arrive_up;
    logic                  w_arrive_dn;

    assign w_clr_en = bus.open_cur & (bus.pos_cur == POS_FLOOR);
    assign w_sel    = NUM_FLOORS'(1) << r_floor;
    assign w_clr_in = w_clr_en ? w_sel : '0;
    // A car still committed to one direction keeps the opposite hall call.
    assign w_clr_up = (w_clr_en && bus.dir_cur != DIR_DN) ? w_sel : '0;
    assign w_clr_dn = (w_clr_en && bus.dir_cur != DIR_UP) ? w_sel : '0;

    assign w_arrive_up = (r_pos_prev == POS_HALF_UP) & (bus.pos_cur == POS_FLOOR);
    assign w_arrive_dn = (r_pos_prev == POS_HALF_DN) & (bus.pos_cur == POS_FLOOR);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pend_up   <= '0;
            r_pend_dn   <= '0;
            r_pend_in   <= '0;
            r_floor     <= '0;
            r_pos_prev  <= POS_FLOOR;
            r_range_err <= 1'b0;
        end else begin
            r_pend_up  <= (r_pend_up | (bus.hall_up_req & c_up_mask)) & ~w_clr_up;
            r_pend_dn  <= (r_pend_dn | (bus.hall_dn_req & c_dn_mask)) & ~w_clr_dn;
            r_pend_in  <= (r_pend_in | bus.car_req) & ~w_clr_in;
            r_pos_prev <= bus.pos_cur;
            if (w_arrive_up) begin
                if (r_floor == c_top) r_range_err <= 1'b1;
                else                  r_floor     <= r_floor + 1'b1;
            end else if (w_arrive_dn) begin
                if (r_floor == c_bottom) r_range_err <= 1'b1;
                else                     r_floor     <= r_floor - 1'b1;
            end
        end
    end

    elev_rel_map #(.NUM_FLOORS(NUM_FLOORS), .FLOOR_W(FLOOR_W)) u_map_up (
        .pending   (r_pend_up),
        .floor_idx (r_floor),
        .rel       (bus.button_up)
    );

    elev_rel_map #(.NUM_FLOORS(NUM_FLOORS), .FLOOR_W(FLOOR_W)) u_map_dn (
        .pending   (r_pend_dn),
        .floor_idx (r_floor),
        .rel       (bus.button_down)
    );

    elev_rel_map #(.NUM_FLOORS(NUM_FLOORS), .FLOOR_W(FLOOR_W)) u_map_in (
        .pending   (r_pend_in),
        .floor_idx (r_floor),
        .rel       (bus.button_in)
    );

    assign bus.floor_cur = r_floor;
    assign bus.pend_any  = |(r_pend_up | r_pend_dn | r_pend_in);
    assign bus.range_err = r_range_err;

endmodule : elev_request_tracker
`default_nettype wire

// File: tb/tb_elev_request_tracker.sv
`default_nettype none
// ============================================================================
//  Module : tb_elev_request_tracker
//  Brief  : Scoreboard bench for elev_request_tracker with a floor-level model.
//  Rev    : 1.0
// ============================================================================
module tb_elev_request_tracker;
    import elev_pkg::*;

    localparam int N  = 4;
    localparam int FW = $clog2(N);

    typedef struct packed {
        logic [2:0]    up;
        logic [2:0]    dn;
        logic [2:0]    in;
        logic [FW-1:0] floor;
        logic          any;
        logic          err;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    elev_request_tracker_if #(.NUM_FLOORS(N)) bus ();

    elev_request_tracker #(.NUM_FLOORS(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];

    // Reference state: per-floor request flags and an integer floor number.
    bit   m_up[N];
    bit   m_dn[N];
    bit   m_in[N];
    int   m_floor;
    int   m_prev;
    bit   m_err;

    function automatic logic [2:0] rel(input bit p[N], input int f);
        logic [2:0] r = 3'b000;
        for (int j = 0; j < N; j++) begin
            if (p[j]) begin
                if (j == f)     r[0] = 1'b1;
                else if (j > f) r[1] = 1'b1;
                else            r[2] = 1'b1;
            end
        end
        return r;
    endfunction

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
        end
    endtask

    task automatic model_step(input logic [N-1:0] hu, input logic [N-1:0] hd,
                              input logic [N-1:0] cr, input int pos, input bit open,
                              input int dir, input bit rst);
        exp_t e;
        bit   any;
        if (rst) begin
            for (int f = 0; f < N; f++) begin
                m_up[f] = 0; m_dn[f] = 0; m_in[f] = 0;
            end
            m_floor = 0; m_prev = 0; m_err = 0;
        end else begin
            bit serve = open && (pos == 0);
            for (int f = 0; f < N; f++) begin
                if (hu[f] && f != N-1) m_up[f] = 1;
                if (hd[f] && f != 0)   m_dn[f] = 1;
                if (cr[f])             m_in[f] = 1;
            end
            if (serve) begin
                m_in[m_floor] = 0;
                if (dir != 2) m_up[m_floor] = 0;
                if (dir != 1) m_dn[m_floor] = 0;
            end
            if (m_prev == 1 && pos == 0) begin
                if (m_floor == N-1) m_err = 1; else m_floor++;
            end else if (m_prev == 2 && pos == 0) begin
                if (m_floor == 0) m_err = 1; else m_floor--;
            end
            m_prev = pos;
        end
        any = 0;
        for (int f = 0; f < N; f++) any = any | m_up[f] | m_dn[f] | m_in[f];
        e.up    = rel(m_up, m_floor);
        e.dn    = rel(m_dn, m_floor);
        e.in    = rel(m_in, m_floor);
        e.floor = FW'(m_floor);
        e.any   = any;
        e.err   = m_err;
        sb.push_back(e);
    endtask

    task automatic step(input logic [N-1:0] hu, input logic [N-1:0] hd,
                        input logic [N-1:0] cr, input logic [1:0] pos, input bit open,
                        input logic [1:0] dir, input bit rst);
        @(negedge clk);
        bus.hall_up_req = hu;
        bus.hall_dn_req = hd;
        bus.car_req     = cr;
        bus.pos_cur     = pos;
        bus.open_cur    = open;
        bus.dir_cur     = dir;
        reset           = rst;
        model_step(hu, hd, cr, int'(pos), open, int'(dir), rst);
    endtask

    task automatic idle(input logic [1:0] pos);
        step('0, '0, '0, pos, 1'b0, DIR_IDLE, 1'b0);
    endtask

    task automatic do_reset();
        step('0, '0, '0, POS_FLOOR, 1'b0, DIR_IDLE, 1'b1);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    // Monitor: the DUT presents a fresh result after every edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("sb_button_up",   int'(bus.button_up),   int'(e.up));
                check("sb_button_down", int'(bus.button_down), int'(e.dn));
                check("sb_button_in",   int'(bus.button_in),   int'(e.in));
                check("sb_floor_cur",   int'(bus.floor_cur),   int'(e.floor));
                check("sb_pend_any",    int'(bus.pend_any),    int'(e.any));
                check("sb_range_err",   int'(bus.range_err),   int'(e.err));
            end
        end
    end

    initial begin
        bus.hall_up_req = '0;
        bus.hall_dn_req = '0;
        bus.car_req     = '0;
        bus.pos_cur     = POS_FLOOR;
        bus.open_cur    = 1'b0;
        bus.dir_cur     = DIR_IDLE;

        // Reset state, then a car call two floors up.
        do_reset();
        settle();
        check("rst_floor", int'(bus.floor_cur), 0);
        check("rst_any",   int'(bus.pend_any),  0);
        check("rst_in",    int'(bus.button_in), 0);
        step('0, '0, 4'b0100, POS_FLOOR, 1'b0, DIR_IDLE, 1'b0);
        settle();
        check("t1_in",   int'(bus.button_in),   3'b010);
        check("t1_up",   int'(bus.button_up),   0);
        check("t1_down", int'(bus.button_down), 0);
        check("t1_any",  int'(bus.pend_any),    1);

        // Floor 2: hall up below, hall down above.
        do_reset();
        idle(POS_HALF_UP); idle(POS_FLOOR); idle(POS_HALF_UP); idle(POS_FLOOR);
        step(4'b0001, 4'b1000, '0, POS_FLOOR, 1'b0, DIR_IDLE, 1'b0);
        settle();
        check("t2_floor", int'(bus.floor_cur),   2);
        check("t2_up",    int'(bus.button_up),   3'b100);
        check("t2_down",  int'(bus.button_down), 3'b010);

        // Floor 1 service while heading up keeps the down call.
        do_reset();
        idle(POS_HALF_UP); idle(POS_FLOOR);
        step(4'b0010, 4'b0010, 4'b0010, POS_FLOOR, 1'b0, DIR_IDLE, 1'b0);
        step('0, '0, '0, POS_FLOOR, 1'b1, DIR_UP, 1'b0);
        settle();
        check("t3_in0",   int'(bus.button_in[0]),   0);
        check("t3_up0",   int'(bus.button_up[0]),   0);
        check("t3_down0", int'(bus.button_down[0]), 1);

        // Floor tracking up twice then down once.
        do_reset();
        idle(POS_HALF_UP); idle(POS_FLOOR); idle(POS_HALF_UP); idle(POS_FLOOR);
        settle();
        check("t4_floor2", int'(bus.floor_cur), 2);
        idle(POS_HALF_DN); idle(POS_FLOOR);
        settle();
        check("t4_floor1", int'(bus.floor_cur), 1);

        // Overrun at the top floor is sticky until reset.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            idle(POS_HALF_UP); idle(POS_FLOOR);
        end
        idle(POS_HALF_UP); idle(POS_FLOOR);
        settle();
        check("t5_floor", int'(bus.floor_cur), 3);
        check("t5_err",   int'(bus.range_err), 1);
        idle(POS_HALF_DN); idle(POS_FLOOR);
        settle();
        check("t5_err_sticky", int'(bus.range_err), 1);
        do_reset();
        settle();
        check("t5_err_rst", int'(bus.range_err), 0);

        // Underrun at floor 0.
        idle(POS_HALF_DN); idle(POS_FLOOR);
        settle();
        check("t5_floor0",  int'(bus.floor_cur), 0);
        check("t5_err_bot", int'(bus.range_err), 1);

        // Press at the open-door floor is dropped; reset wipes pending state.
        do_reset();
        step('0, '0, 4'b0001, POS_FLOOR, 1'b1, DIR_IDLE, 1'b0);
        settle();
        check("t6_drop_in",  int'(bus.button_in), 0);
        check("t6_drop_any", int'(bus.pend_any),  0);
        step(4'b1111, 4'b1111, 4'b1110, POS_FLOOR, 1'b0, DIR_IDLE, 1'b0);
        do_reset();
        settle();
        check("t6_rst_up",  int'(bus.button_up),   0);
        check("t6_rst_dn",  int'(bus.button_down), 0);
        check("t6_rst_in",  int'(bus.button_in),   0);
        check("t6_rst_any", int'(bus.pend_any),    0);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            logic [N-1:0] hu, hd, cr;
            logic [1:0]   pos, dir;
            bit           open, rst;
            hu   = N'($urandom & $urandom & $urandom);
            hd   = N'($urandom & $urandom & $urandom);
            cr   = N'($urandom & $urandom & $urandom);
            pos  = 2'($urandom_range(0, 2));
            dir  = 2'($urandom_range(0, 2));
            open = ($urandom_range(0, 2) == 0);
            rst  = ($urandom_range(0, 59) == 0);
            step(hu, hd, cr, pos, open, dir, rst);
        end
        idle(POS_FLOOR);
        settle();
        settle();
        check("sb_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_elev_request_tracker
`default_nettype wire
